// File: rtl/receiver_i2c.sv
// I2C target: decodes START/STOP, matches a 7-bit address, captures a 16-bit write word
// and serialises a 16-bit word back on reads. SCL/SDA are sampled on the system clock.
module receiver_i2c #(
    parameter logic [6:0] DEV_ADDR = 7'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCL,
    input  logic        SDA_OUT,
    input  logic        SDA_OE,
    input  logic [15:0] TX_DATA,
    output logic        SDA_IN,
    output logic        SDA_IN_ACK,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StHold
    } state_e;

    state_e      state_q, state_d;
    logic        scl_q, sda_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_cnt_q, byte_cnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  byte0_q, byte0_d;
    logic        rnw_q, rnw_d;
    logic [15:0] tx_reg_q, tx_reg_d;
    logic        sda_in_q, sda_in_d;
    logic        ack_q, ack_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        busy_q, busy_d;

    logic       sda_bus;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shreg_shift;
    logic       last_bit, addr_match;

    assign sda_bus     = SDA_OE ? SDA_OUT : 1'b1;
    assign scl_rise    = SCL & ~scl_q;
    assign scl_fall    = ~SCL & scl_q;
    assign start_det   = SCL & scl_q & sda_q & ~sda_bus;
    assign stop_det    = SCL & scl_q & ~sda_q & sda_bus;
    assign shreg_shift = {shreg_q[6:0], sda_bus};
    assign last_bit    = (bit_cnt_q == 3'd7);
    assign addr_match  = (shreg_shift[7:1] == DEV_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = StIdle;
        end else if (start_det) begin
            state_d = StAddr;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise && last_bit) state_d = addr_match ? StAddrAck : StHold;
                end
                StAddrAck: begin
                    if (scl_fall && phase_q) state_d = rnw_q ? StRdByte : StWrByte;
                end
                StWrByte: begin
                    if (scl_rise && last_bit) state_d = StWrAck;
                end
                StWrAck: begin
                    if (scl_fall && phase_q) state_d = byte_cnt_q ? StHold : StWrByte;
                end
                StRdByte: begin
                    if (scl_rise && last_bit) state_d = StRdAck;
                end
                StRdAck: begin
                    if (scl_fall && phase_q) state_d = byte_cnt_q ? StHold : StRdByte;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and registered outputs; ACK states use phase_q to tell the fall that opens
    // the ninth-bit slot from the fall that closes it.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        phase_d    = phase_q;
        shreg_d    = shreg_q;
        byte0_d    = byte0_q;
        rnw_d      = rnw_q;
        tx_reg_d   = tx_reg_q;
        sda_in_d   = sda_in_q;
        ack_d      = ack_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = (state_d != StIdle);
        if (stop_det || start_det) begin
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 1'b0;
            phase_d    = 1'b0;
            sda_in_d   = 1'b0;
            ack_d      = 1'b0;
        end else begin
            case (state_q)
                StAddr, StWrByte: begin
                    if (scl_rise) begin
                        shreg_d   = shreg_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (state_q == StAddr && last_bit) rnw_d = sda_bus;
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            ack_d   = 1'b1;
                            if (rnw_q) tx_reg_d = TX_DATA;
                        end else begin
                            phase_d = 1'b0;
                            ack_d   = 1'b0;
                            if (rnw_q) sda_in_d = tx_reg_q[15];
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            ack_d   = 1'b1;
                            if (byte_cnt_q) begin
                                rx_data_d  = {byte0_q, shreg_q};
                                rx_valid_d = 1'b1;
                            end else begin
                                byte0_d = shreg_q;
                            end
                        end else begin
                            phase_d    = 1'b0;
                            ack_d      = 1'b0;
                            byte_cnt_d = 1'b1;
                        end
                    end
                end
                StRdByte: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 3'd1;
                    if (scl_fall) sda_in_d = tx_reg_q[{~byte_cnt_q, ~bit_cnt_q}];
                end
                StRdAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d  = 1'b1;
                            sda_in_d = 1'b0;
                        end else begin
                            phase_d    = 1'b0;
                            byte_cnt_d = 1'b1;
                            sda_in_d   = byte_cnt_q ? 1'b0 : tx_reg_q[7];
                        end
                    end
                end
                StHold: begin
                    sda_in_d = 1'b0;
                    ack_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_q      <= 1'b0;
            sda_q      <= 1'b0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 1'b0;
            phase_q    <= 1'b0;
            shreg_q    <= 8'd0;
            byte0_q    <= 8'd0;
            rnw_q      <= 1'b0;
            tx_reg_q   <= 16'd0;
            sda_in_q   <= 1'b0;
            ack_q      <= 1'b0;
            rx_data_q  <= 16'd0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_q      <= SCL;
            sda_q      <= sda_bus;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            byte0_q    <= byte0_d;
            rnw_q      <= rnw_d;
            tx_reg_q   <= tx_reg_d;
            sda_in_q   <= sda_in_d;
            ack_q      <= ack_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign SDA_IN     = sda_in_q;
    assign SDA_IN_ACK = ack_q;
    assign RX_DATA    = rx_data_q;
    assign RX_VALID   = rx_valid_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_receiver_i2c.sv
// Bench for receiver_i2c: bit-banged I2C master with directed scenarios and a randomized
// transaction loop checked against a transaction-level model of the target.
module tb_receiver_i2c;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        SCL = 1'b1;
    logic        SDA_OUT = 1'b1;
    logic        SDA_OE = 1'b0;
    logic [15:0] TX_DATA = 16'd0;
    logic        SDA_IN, SDA_IN_ACK, RX_VALID, BUSY;
    logic [15:0] RX_DATA;

    int checks = 0;
    int errors = 0;
    int vtotal = 0;
    logic [15:0] exp_rx = 16'd0;

    receiver_i2c #(.DEV_ADDR(7'h5A)) dut (
        .clk(clk), .rst(rst), .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE),
        .TX_DATA(TX_DATA), .SDA_IN(SDA_IN), .SDA_IN_ACK(SDA_IN_ACK),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    // Total clocks RX_VALID has been high; a single pulse adds exactly one.
    always @(posedge clk) if (RX_VALID === 1'b1) vtotal <= vtotal + 1;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic oe, input logic val, output logic in_s, output logic ack_s);
        SDA_OE = oe; SDA_OUT = val;
        wait_clks(4);
        SCL = 1'b1;
        wait_clks(2);
        in_s = SDA_IN; ack_s = SDA_IN_ACK;
        wait_clks(2);
        SCL = 1'b0;
        wait_clks(1);
    endtask

    task automatic i2c_start();
        SDA_OE = 1'b1; SDA_OUT = 1'b1;
        wait_clks(2);
        SCL = 1'b1;
        wait_clks(3);
        SDA_OUT = 1'b0;
        wait_clks(3);
        SCL = 1'b0;
        wait_clks(2);
    endtask

    task automatic i2c_stop();
        SDA_OE = 1'b1; SDA_OUT = 1'b0;
        wait_clks(2);
        SCL = 1'b1;
        wait_clks(3);
        SDA_OUT = 1'b1;
        wait_clks(2);
        SDA_OE = 1'b0;
        wait_clks(3);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic stray);
        logic d, a;
        stray = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, b[i], d, a);
            stray |= a;
        end
        bus_bit(1'b0, 1'b1, d, acked);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d, output logic slot_in,
                             output logic any_ack);
        logic s, a;
        any_ack = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b0, 1'b1, s, a);
            d[i] = s;
            any_ack |= a;
        end
        bus_bit(mack, ~mack, slot_in, a);
        any_ack |= a;
    endtask

    task automatic test_reset();
        wait_clks(3);
        checks++;
        if ({SDA_IN, SDA_IN_ACK, RX_DATA, RX_VALID, BUSY} !== 20'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h expected 0", {SDA_IN, SDA_IN_ACK, RX_DATA, RX_VALID, BUSY});
        end
        rst = 1'b1;
        wait_clks(4);
        checks++;
        if ({SDA_IN, SDA_IN_ACK, RX_DATA, RX_VALID, BUSY} !== 20'd0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h expected 0", {SDA_IN, SDA_IN_ACK, RX_DATA, RX_VALID, BUSY});
        end
    endtask

    task automatic test_write();
        logic a0, a1, a2, s0, s1, s2;
        int v0;
        v0 = vtotal;
        i2c_start();
        send_byte({7'h5A, 1'b0}, a0, s0);
        send_byte(8'hBE, a1, s1);
        send_byte(8'hEF, a2, s2);
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", BUSY); end
        i2c_stop();
        exp_rx = 16'hBEEF;
        checks++;
        if ({a0, a1, a2, s0, s1, s2} !== 6'b111000) begin
            errors++; $display("FAIL write_acks: acks/stray=%b expected 111000", {a0, a1, a2, s0, s1, s2});
        end
        checks++;
        if (RX_DATA !== exp_rx) begin errors++; $display("FAIL write_data: got %h expected %h", RX_DATA, exp_rx); end
        checks++;
        if (vtotal - v0 != 1) begin errors++; $display("FAIL write_valid: clocks high %0d expected 1", vtotal - v0); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL write_idle: busy=%b expected 0", BUSY); end
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2, s0, s1, s2;
        int v0;
        v0 = vtotal;
        i2c_start();
        send_byte({7'h11, 1'b0}, a0, s0);
        send_byte(8'h12, a1, s1);
        send_byte(8'h34, a2, s2);
        i2c_stop();
        checks++;
        if ({a0, a1, a2, s0, s1, s2} !== 6'b000000) begin
            errors++; $display("FAIL mismatch_acks: acks/stray=%b expected 000000", {a0, a1, a2, s0, s1, s2});
        end
        checks++;
        if (vtotal != v0 || RX_DATA !== exp_rx) begin
            errors++; $display("FAIL mismatch_data: rx=%h valid_clks=%0d expected %h/0", RX_DATA, vtotal - v0, exp_rx);
        end
    endtask

    task automatic test_read();
        logic a0, s0, sl0, sl1, x0, x1;
        logic [7:0] d0, d1;
        TX_DATA = 16'hA55A;
        i2c_start();
        send_byte({7'h5A, 1'b1}, a0, s0);
        TX_DATA = 16'h0000;
        recv_byte(1'b1, d0, sl0, x0);
        recv_byte(1'b0, d1, sl1, x1);
        i2c_stop();
        checks++;
        if (a0 !== 1'b1 || s0 !== 1'b0) begin errors++; $display("FAIL read_addr_ack: ack=%b stray=%b expected 1/0", a0, s0); end
        checks++;
        if ({d0, d1} !== 16'hA55A) begin errors++; $display("FAIL read_data: got %h expected a55a", {d0, d1}); end
        checks++;
        if ({sl0, sl1, x0, x1} !== 4'b0000) begin
            errors++; $display("FAIL read_ack_slots: sda_in slots/acks=%b expected 0000", {sl0, sl1, x0, x1});
        end
    endtask

    task automatic test_abort();
        logic a0, a1, a2, s0, s1, s2;
        int v0;
        v0 = vtotal;
        i2c_start();
        send_byte({7'h5A, 1'b0}, a0, s0);
        send_byte(8'hCA, a1, s1);
        i2c_stop();
        checks++;
        if (vtotal != v0 || RX_DATA !== exp_rx || a1 !== 1'b1) begin
            errors++; $display("FAIL abort_keep: rx=%h valid_clks=%0d ack=%b expected %h/0/1", RX_DATA, vtotal - v0, a1, exp_rx);
        end
        v0 = vtotal;
        i2c_start();
        send_byte({7'h5A, 1'b0}, a0, s0);
        send_byte(8'h01, a1, s1);
        send_byte(8'h02, a2, s2);
        i2c_stop();
        exp_rx = 16'h0102;
        checks++;
        if (RX_DATA !== exp_rx || vtotal - v0 != 1) begin
            errors++; $display("FAIL abort_next: rx=%h valid_clks=%0d expected %h/1", RX_DATA, vtotal - v0, exp_rx);
        end
    endtask

    task automatic test_restart();
        logic a0, a1, a2, s0, s1, s2, d, a;
        int v0;
        v0 = vtotal;
        i2c_start();
        send_byte({7'h5A, 1'b0}, a0, s0);
        send_byte(8'h55, a1, s1);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, i[0], d, a);
        i2c_start();
        send_byte({7'h5A, 1'b0}, a0, s0);
        send_byte(8'h7E, a1, s1);
        send_byte(8'h81, a2, s2);
        i2c_stop();
        exp_rx = 16'h7E81;
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL restart_acks: got %b expected 111", {a0, a1, a2}); end
        checks++;
        if (RX_DATA !== exp_rx || vtotal - v0 != 1) begin
            errors++; $display("FAIL restart_data: rx=%h valid_clks=%0d expected %h/1", RX_DATA, vtotal - v0, exp_rx);
        end
    endtask

    task automatic test_reset_mid_read();
        logic a0, s0, d, a, a1, a2, s1, s2;
        logic [15:0] tx;
        int v0;
        tx = 16'($urandom) | 16'h0400;
        TX_DATA = tx;
        i2c_start();
        send_byte({7'h5A, 1'b1}, a0, s0);
        for (int i = 0; i < 5; i++) bus_bit(1'b0, 1'b1, d, a);
        SDA_OE = 1'b0;
        wait_clks(4);
        SCL = 1'b1;
        wait_clks(2);
        checks++;
        if (SDA_IN !== tx[10] || BUSY !== 1'b1) begin
            errors++; $display("FAIL midread_bit5: sda_in=%b busy=%b expected %b/1", SDA_IN, BUSY, tx[10]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({SDA_IN, SDA_IN_ACK, RX_DATA, RX_VALID, BUSY} !== 20'd0) begin
            errors++; $display("FAIL midread_async_reset: outputs=%h expected 0", {SDA_IN, SDA_IN_ACK, RX_DATA, RX_VALID, BUSY});
        end
        exp_rx = 16'd0;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(3);
        v0 = vtotal;
        i2c_start();
        send_byte({7'h5A, 1'b0}, a0, s0);
        send_byte(8'h00, a1, s1);
        send_byte(8'hFF, a2, s2);
        i2c_stop();
        exp_rx = 16'h00FF;
        checks++;
        if (RX_DATA !== exp_rx || vtotal - v0 != 1 || {a0, a1, a2} !== 3'b111) begin
            errors++; $display("FAIL postreset_write: rx=%h valid_clks=%0d acks=%b expected %h/1/111", RX_DATA, vtotal - v0, {a0, a1, a2}, exp_rx);
        end
    endtask

    // Model: the target ACKs only its own address, at most two write bytes, and returns
    // TX_DATA MSB-first on reads; anything unaddressed reads back as zeros.
    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            logic [6:0] addr;
            logic rnw, match, ack, stray, sl0, sl1, x0, x1;
            logic [7:0] d0, d1;
            logic [7:0] wb [3];
            logic [15:0] tx, exp_rd;
            int nb, v0, exp_v;
            addr = ($urandom_range(0, 1) == 1) ? 7'h5A : 7'($urandom_range(0, 127));
            rnw = 1'($urandom_range(0, 1));
            match = (addr == 7'h5A);
            tx = 16'($urandom);
            nb = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) wb[i] = 8'($urandom);
            v0 = vtotal;
            TX_DATA = tx;
            i2c_start();
            send_byte({addr, rnw}, ack, stray);
            checks++;
            if (ack !== match || stray !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_addr: ack=%b stray=%b expected %b/0", t, ack, stray, match);
            end
            if (rnw) begin
                recv_byte(1'b1, d0, sl0, x0);
                recv_byte(1'b0, d1, sl1, x1);
                exp_rd = match ? tx : 16'd0;
                checks++;
                if ({d0, d1} !== exp_rd || {sl0, sl1, x0, x1} !== 4'b0000) begin
                    errors++; $display("FAIL rnd%0d_read: data=%h slots=%b expected %h/0000", t, {d0, d1}, {sl0, sl1, x0, x1}, exp_rd);
                end
                exp_v = 0;
            end else begin
                for (int i = 0; i < nb; i++) begin
                    send_byte(wb[i], ack, stray);
                    checks++;
                    if (ack !== (match && i < 2) || stray !== 1'b0) begin
                        errors++; $display("FAIL rnd%0d_wack%0d: ack=%b stray=%b expected %b/0", t, i, ack, stray, match && i < 2);
                    end
                end
                exp_v = (match && nb >= 2) ? 1 : 0;
                if (exp_v == 1) exp_rx = {wb[0], wb[1]};
            end
            i2c_stop();
            checks++;
            if (RX_DATA !== exp_rx || vtotal - v0 != exp_v || BUSY !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_end: rx=%h valid_clks=%0d busy=%b expected %h/%0d/0", t, RX_DATA, vtotal - v0, BUSY, exp_rx, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_abort();
        test_restart();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
